alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational 32-bit ALU (4-bit operation code, zero flag) between two requesters with a valid/ready handshake.
- Requester 0 is the execute micro-op path; requester 1 is the PC/address-update path.
- Sequence per request: register operands, drive the ALU for one cycle, capture result and zero flag, hold the response until the owner accepts it.
- Round-robin arbitration so neither path starves.

Parameters:
- WIDTH, 32, operand/result width.
- OPW, 4, ALU operation code width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  arbiter accepts requester 0 this cycle.
- req0_op  in  OPW  requester 0 operation code.
- req0_a  in  WIDTH  requester 0 operand 1.
- req0_b  in  WIDTH  requester 0 operand 2.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 consumes result.
- rsp1_valid  out  1  result for requester 1 available.
- rsp1_ready  in  1  requester 1 consumes result.
- rsp_data  out  WIDTH  captured ALU result, shared by both responses.
- rsp_zero  out  1  captured ALU zero flag.
- alu_in1  out  WIDTH  to ALU operand 1.
- alu_in2  out  WIDTH  to ALU operand 2.
- alu_op  out  OPW  to ALU operation.
- alu_out  in  WIDTH  from ALU result.
- alu_zero  in  1  from ALU zero flag.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values (asynchronous, rst_n=0):
  - Operand, op, result and zero registers all 0.
  - owner=0; last_grant=1, so requester 0 wins the first tie.
  - All ready/valid outputs 0; busy 0.
- alu_in1, alu_in2, alu_op are always driven from the operand/op registers. They are never combinational from request inputs.
- IDLE:
  - Winner: if only one valid is high, that requester wins. If both are high, the requester other than last_grant wins.
  - reqN_ready = (state==IDLE) & reqN_valid & winner==N. This is combinational and at most one ready is high.
  - On a handshake (valid & ready): latch op, a, b and owner=N, then go to EXEC.
  - If no valid is high, stay in IDLE.
- EXEC, exactly one cycle:
  - The ALU settles on the registered operands.
  - At the clock edge, rsp_data<=alu_out and rsp_zero<=alu_zero; go to RESP.
- RESP:
  - rsp{owner}_valid=1; the other rsp valid stays 0.
  - rsp_data and rsp_zero are held stable while waiting.
  - When rsp{owner}_ready=1: last_grant<=owner, go to IDLE.
  - The non-owner's rsp_ready is ignored.
- Timing:
  - Latency: accept at edge T, rsp valid from cycle T+2.
  - Best-case throughput: one operation per 3 cycles, with rsp_ready tied high.
  - A new request cannot be accepted in the same cycle a response completes. Accepting it requires IDLE.
- Requester rules: hold valid/op/a/b stable until ready. The arbiter does not check this.
- Deasserting valid before ready is legal; no state change results.
- Operands are passed through unmodified; sign and overflow semantics belong to the ALU.
- rsp_data and rsp_zero keep the last captured value after the response is consumed, until the next EXEC.
- Reset mid-operation (EXEC or RESP):
  - Immediate return to IDLE with all registers at reset values.
  - The in-flight request is discarded and no response is issued.
  - The requester must re-issue.
- Back-to-back with both requesters continuously valid: grants alternate 0,1,0,1…

Test Plan:
- Reset then idle: rst_n=0 then 1, no valids → all outputs 0, busy=0, state stays IDLE for 10 cycles.
- Single request: req0 op=4'b0010, a=32'hFFFF_FFFE, b=32'hFFFF_FFFD, bench ALU model returns a+b → req0_ready in accept cycle; alu_in1/alu_in2 equal the operands from the next cycle; rsp0_valid two cycles after accept; rsp_data=32'hFFFF_FFFB, rsp_zero=0; rsp1_valid never asserted.
- Simultaneous first requests: both valid from reset → req0 granted first; after rsp0 is consumed, req1 granted; then 0 again. Check 6 grants alternate.
- Response backpressure: rsp0_ready held 0 for 5 cycles → rsp0_valid, rsp_data and busy stable; req1_valid high but req1_ready stays 0 until one cycle after rsp0_ready=1.
- Zero flag: req1 a=5, b=5, op=subtract model → rsp_data=0, rsp_zero=1 on rsp1_valid.
- Reset mid-op: assert rst_n=0 during EXEC → outputs 0 immediately without a clock edge; after release, no rsp issued and req0 (still valid) wins the next arbitration.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute path (requester 0) and the
// PC/address-update path (requester 1) with round-robin arbitration.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic             owner;
  logic             last_grant;
  logic             grant0_c;
  logic             grant1_c;
  logic             rsp_done_c;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (state == IDLE) begin
      grant0_c = req0_valid & (~req1_valid | last_grant);
      grant1_c = req1_valid & (~req0_valid | ~last_grant);
    end
  end

  always_comb begin
    rsp_done_c = 1'b0;
    if (state == RESP) begin
      rsp_done_c = owner ? rsp1_ready : rsp0_ready;
    end
  end

  assign req0_ready = grant0_c;
  assign req1_ready = grant1_c;

  // ALU is fed only from registered operands, never straight from a requester.
  assign alu_in1 = a_q;
  assign alu_in2 = b_q;
  assign alu_op  = op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0_c) begin
            a_q   <= req0_a;
            b_q   <= req0_b;
            op_q  <= req0_op;
            owner <= 1'b0;
            busy  <= 1'b1;
            state <= EXEC;
          end else if (grant1_c) begin
            a_q   <= req1_a;
            b_q   <= req1_b;
            op_q  <= req1_op;
            owner <= 1'b1;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data   <= alu_out;
          rsp_zero   <= alu_zero;
          rsp0_valid <= ~owner;
          rsp1_valid <= owner;
          state      <= RESP;
        end
        RESP: begin
          // Result stays held after the handshake until the next EXEC.
          if (rsp_done_c) begin
            last_grant <= owner;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_share_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned OPW   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OPW-1:0]   req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic [WIDTH-1:0] alu_in1, alu_in2, alu_out;
  logic [OPW-1:0]   alu_op;
  logic             alu_zero;
  logic             busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
  );

  // Bench ALU: 0 and, 1 or, 2 add, 6 subtract, 7 signed less-than, else xor.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_out  = alu_f(alu_op, alu_in1, alu_in2);
  assign alu_zero = (alu_out == 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  // Transaction model: one operation in flight, aged in cycles since acceptance.
  logic        m_active, m_owner, m_last, m_zero;
  int          m_age;
  logic [31:0] m_a, m_b, m_res, m_data;
  logic [3:0]  m_op;
  logic        exp_rdy0, exp_rdy1;

  always_comb begin
    exp_rdy0 = !m_active && req0_valid && (!req1_valid || m_last);
    exp_rdy1 = !m_active && req1_valid && (!req0_valid || !m_last);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_age    <= 0;
      m_owner  <= 1'b0;
      m_last   <= 1'b1;
      m_a      <= '0;
      m_b      <= '0;
      m_op     <= '0;
      m_res    <= '0;
      m_data   <= '0;
      m_zero   <= 1'b0;
    end else if (m_active) begin
      if (m_age == 1) begin
        m_data <= m_res;
        m_zero <= (m_res == 32'd0);
        m_age  <= 2;
      end else if ((!m_owner && rsp0_ready) || (m_owner && rsp1_ready)) begin
        m_active <= 1'b0;
        m_last   <= m_owner;
      end
    end else if (exp_rdy0) begin
      m_active <= 1'b1;
      m_age    <= 1;
      m_owner  <= 1'b0;
      m_a      <= req0_a;
      m_b      <= req0_b;
      m_op     <= req0_op;
      m_res    <= alu_f(req0_op, req0_a, req0_b);
    end else if (exp_rdy1) begin
      m_active <= 1'b1;
      m_age    <= 1;
      m_owner  <= 1'b1;
      m_a      <= req1_a;
      m_b      <= req1_b;
      m_op     <= req1_op;
      m_res    <= alu_f(req1_op, req1_a, req1_b);
    end
  end

  always @(negedge clk) begin
    chk1("req0_ready", req0_ready, exp_rdy0);
    chk1("req1_ready", req1_ready, exp_rdy1);
    chk1("rsp0_valid", rsp0_valid, m_active && (m_age == 2) && !m_owner);
    chk1("rsp1_valid", rsp1_valid, m_active && (m_age == 2) && m_owner);
    chk1("busy", busy, m_active);
    chk("alu_in1", alu_in1, m_a);
    chk("alu_in2", alu_in2, m_b);
    chk("alu_op", 32'(alu_op), 32'(m_op));
    chk("rsp_data", rsp_data, m_data);
    chk1("rsp_zero", rsp_zero, m_zero);
  end

  int   grants[$];
  logic hs0, hs1;

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req1_op = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset then idle
    repeat (3) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_req0_ready", req0_ready, 1'b0);
    end

    // Single request with carry-out wrap
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'hFFFF_FFFE; req0_b = 32'hFFFF_FFFD;
    @(negedge clk);
    chk1("single_ready", req0_ready, 1'b1);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    chk("single_alu_in1", alu_in1, 32'hFFFF_FFFE);
    chk("single_alu_in2", alu_in2, 32'hFFFF_FFFD);
    chk("single_alu_op", 32'(alu_op), 32'd2);
    chk1("single_exec_rsp0", rsp0_valid, 1'b0);
    @(negedge clk);
    chk1("single_rsp0_valid", rsp0_valid, 1'b1);
    chk1("single_rsp1_valid", rsp1_valid, 1'b0);
    chk("single_rsp_data", rsp_data, 32'hFFFF_FFFB);
    chk1("single_rsp_zero", rsp_zero, 1'b0);
    @(posedge clk); #1 rsp0_ready = 1'b1;
    @(posedge clk); #1 rsp0_ready = 1'b0;
    @(negedge clk);
    chk1("single_done_busy", busy, 1'b0);
    chk("single_data_held", rsp_data, 32'hFFFF_FFFB);

    // Both valid straight out of reset: grants alternate starting with 0
    @(posedge clk); #1 rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'h0000_00F0; req0_b = 32'h0000_000F;
    req1_valid = 1'b1; req1_op = 4'd3; req1_a = 32'h1234_5678; req1_b = 32'h1111_1111;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    grants.delete();
    for (int c = 0; c < 40 && grants.size() < 6; c++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) grants.push_back(0);
      if (req1_valid && req1_ready) grants.push_back(1);
    end
    chk("grant_count", 32'(grants.size()), 32'd6);
    for (int i = 0; i < grants.size(); i++) chk("grant_order", 32'(grants[i]), 32'(i % 2));
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Response backpressure while requester 1 waits
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00;
    @(negedge clk);
    chk1("bp_req0_ready", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'h0000_0003; req1_b = 32'h0000_0030;
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk1("bp_rsp0_valid", rsp0_valid, 1'b1);
      chk1("bp_busy", busy, 1'b1);
      chk("bp_rsp_data", rsp_data, 32'hF000_F000);
      chk1("bp_req1_ready", req1_ready, 1'b0);
    end
    @(posedge clk); #1 rsp0_ready = 1'b1;
    @(negedge clk);
    chk1("bp_req1_ready_same", req1_ready, 1'b0);
    @(posedge clk); #1 rsp0_ready = 1'b0;
    @(negedge clk);
    chk1("bp_req1_ready_after", req1_ready, 1'b1);
    @(posedge clk); #1 req1_valid = 1'b0; rsp1_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rsp1_ready = 1'b0;

    // Zero flag through requester 1
    req1_valid = 1'b1; req1_op = 4'd6; req1_a = 32'd5; req1_b = 32'd5;
    @(negedge clk);
    chk1("zero_req1_ready", req1_ready, 1'b1);
    @(posedge clk); #1 req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("zero_rsp1_valid", rsp1_valid, 1'b1);
    chk1("zero_rsp0_valid", rsp0_valid, 1'b0);
    chk("zero_rsp_data", rsp_data, 32'd0);
    chk1("zero_rsp_zero", rsp_zero, 1'b1);
    @(posedge clk); #1 rsp1_ready = 1'b1;
    @(posedge clk); #1 rsp1_ready = 1'b0;

    // Reset during EXEC discards the operation
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'd1; req0_b = 32'd2;
    @(negedge clk);
    chk1("mid_req0_ready", req0_ready, 1'b1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk1("mid_busy", busy, 1'b0);
    chk("mid_alu_in1", alu_in1, 32'd0);
    chk("mid_alu_op", 32'(alu_op), 32'd0);
    chk("mid_rsp_data", rsp_data, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk1("mid_rsp0_valid", rsp0_valid, 1'b0);
    chk1("mid_req0_regrant", req0_ready, 1'b1);
    @(posedge clk); #1 req0_valid = 1'b0; rsp0_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rsp0_ready = 1'b0;

    // Randomized traffic, with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (!req0_valid || hs0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_op    = 4'($urandom_range(0, 15));
        req0_a     = $urandom;
        req0_b     = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        req0_valid = 1'b0;
      end
      if (!req1_valid || hs1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_op    = 4'($urandom_range(0, 15));
        req1_a     = $urandom;
        req1_b     = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        req1_valid = 1'b0;
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
